mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 72 +++++++
 tb/tb_mem_port_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Define MEM_PORT_ARB_RR_EN for round-robin on ties instead of fixed data priority.
module mem_port_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [0:31]      i_addr,
  output logic             i_ack,
  output logic             i_err,
  output logic [0:31]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [0:31]      d_addr,
  input  logic [0:31]      d_wdata,
  input  logic [0:1]       d_dsize,
  output logic             d_ack,
  output logic             d_err,
  output logic [0:31]      d_rdata,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic             m_we,
  output logic [1:0]       m_dsize,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t state;
  logic pick_d, i_bad, d_bad, err, we_ok;
`ifdef MEM_PORT_ARB_RR_EN
  logic last_d;
  assign pick_d = d_req & (~i_req | ~last_d);
`else
  assign pick_d = d_req;
`endif
  // Bit 31 is the address LSB in this big-endian numbering.
  assign i_bad = i_addr[30:31] != 2'b00;
  assign d_bad = (d_dsize == 2'd2) | ((d_dsize == 2'd3) & (d_addr[30:31] != 2'b00)) |
                 ((d_dsize == 2'd1) & d_addr[31]);
  assign i_ack = state == GNT_I;
  assign d_ack = state == GNT_D;
  assign i_err = i_ack & err;
  assign d_err = d_ack & err;
  assign m_we = d_ack & we_ok;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      err <= 1'b0;
      we_ok <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_dsize <= '0;
      conflict_cnt <= '0;
`ifdef MEM_PORT_ARB_RR_EN
      last_d <= 1'b0;
`endif
    end else begin
      state <= pick_d ? GNT_D : i_req ? GNT_I : IDLE;
      err <= pick_d ? d_bad : i_bad;
      we_ok <= pick_d & d_we & ~d_bad;
      m_addr <= pick_d ? d_addr : i_req ? i_addr : m_addr;
      m_wdata <= pick_d ? d_wdata : m_wdata;
      m_dsize <= pick_d ? d_dsize : i_req ? 2'd3 : m_dsize;
      if (i_req & d_req & ~&conflict_cnt) conflict_cnt <= conflict_cnt + 1'b1;
`ifdef MEM_PORT_ARB_RR_EN
      last_d <= pick_d ? 1'b1 : i_req ? 1'b0 : last_d;
`endif
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus grant, reset and saturation sequences for mem_port_arbiter.
module tb_mem_port_arbiter;
  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq, dwe; logic [31:0] daddr, dwdata; logic [1:0] dsize; logic [31:0] rdata;
    logic ei, eie, ed, ede, ewe; logic [31:0] eaddr; logic [1:0] edsize;
  } vec_t;
  typedef struct {
    logic ei, eie, ed, ede, ewe; logic [31:0] eaddr, ewdata, erdata; logic [1:0] edsize; int ecnt;
  } exp_t;
  logic clk = 0, rst_n = 1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [1:0] d_dsize = 0;
  logic i_ack, i_err, d_ack, d_err, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0] m_dsize;
  logic [15:0] conflict_cnt;
  logic i_ack4, i_err4, d_ack4, d_err4, m_we4;
  logic [31:0] i_rdata4, d_rdata4, m_addr4, m_wdata4;
  logic [1:0] m_dsize4;
  logic [3:0] conflict_cnt4;
  int total = 0, passes = 0, writes = 0, cnt_m = 0;
  vec_t tbl[14];
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) if (m_we) writes <= writes + 1;
  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err),
    .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_dsize(d_dsize), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_we(m_we), .m_dsize(m_dsize), .m_rdata(m_rdata),
    .conflict_cnt(conflict_cnt)
  );
  mem_port_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack4), .i_err(i_err4),
    .i_rdata(i_rdata4), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_dsize(d_dsize), .d_ack(d_ack4), .d_err(d_err4), .d_rdata(d_rdata4), .m_addr(m_addr4),
    .m_wdata(m_wdata4), .m_we(m_we4), .m_dsize(m_dsize4), .m_rdata(m_rdata),
    .conflict_cnt(conflict_cnt4)
  );
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic vec_t mk(logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
      logic [31:0] daddr, logic [31:0] dwdata, logic [1:0] dsize, logic [31:0] rdata,
      logic ei, logic eie, logic ed, logic ede, logic ewe, logic [31:0] eaddr, logic [1:0] edsize);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
    v.dwdata = dwdata; v.dsize = dsize; v.rdata = rdata; v.ei = ei; v.eie = eie;
    v.ed = ed; v.ede = ede; v.ewe = ewe; v.eaddr = eaddr; v.edsize = edsize;
    return v;
  endfunction
  task automatic do_reset();
    rst_n = 0; i_req = 0; d_req = 0; d_we = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cnt_m = 0;
  endtask
  initial begin
    vec_t v;
    exp_t e, g;
    int w0;
    //         ireq iaddr  dreq we daddr     dwdata      ds  rdata         ei eie ed ede we eaddr     eds
    tbl[0]  = mk(1, 32'h10,  0, 0, 0,        0,           0, 32'hDEADBEEF, 1, 0, 0, 0, 0, 32'h10,   3);
    tbl[1]  = mk(0, 0,       0, 0, 0,        0,           0, 0,            0, 0, 0, 0, 0, 32'h10,   3);
    tbl[2]  = mk(0, 0,       1, 1, 32'h2002, 32'h0000ABCD,1, 0,            0, 0, 1, 0, 1, 32'h2002, 1);
    tbl[3]  = mk(0, 0,       1, 0, 32'h3000, 0,           3, 32'h12345678, 0, 0, 1, 0, 0, 32'h3000, 3);
    tbl[4]  = mk(0, 0,       1, 1, 32'h2001, 32'h11,      3, 0,            0, 0, 1, 1, 0, 32'h2001, 3);
    tbl[5]  = mk(0, 0,       1, 1, 32'h4000, 32'h22,      2, 0,            0, 0, 1, 1, 0, 32'h4000, 2);
    tbl[6]  = mk(0, 0,       1, 1, 32'h4001, 32'h33,      1, 0,            0, 0, 1, 1, 0, 32'h4001, 1);
    tbl[7]  = mk(0, 0,       1, 1, 32'h4003, 32'h55,      0, 0,            0, 0, 1, 0, 1, 32'h4003, 0);
    tbl[8]  = mk(1, 32'h102, 0, 0, 0,        0,           0, 32'h0BADC0DE, 1, 1, 0, 0, 0, 32'h102,  3);
    tbl[9]  = mk(1, 32'h20,  1, 0, 32'h5000, 0,           3, 32'hCAFE0001, 0, 0, 1, 0, 0, 32'h5000, 3);
`ifdef MEM_PORT_ARB_RR_EN
    tbl[10] = mk(1, 32'h20,  1, 0, 32'h5000, 0,           3, 32'h0BADF00D, 1, 0, 0, 0, 0, 32'h20,   3);
`else
    tbl[10] = mk(1, 32'h20,  1, 0, 32'h5000, 0,           3, 32'h0BADF00D, 0, 0, 1, 0, 0, 32'h5000, 3);
`endif
    tbl[11] = mk(1, 32'h24,  0, 0, 0,        0,           0, 32'h77777777, 1, 0, 0, 0, 0, 32'h24,   3);
    tbl[12] = mk(0, 0,       1, 0, 32'h6006, 0,           1, 32'h0000BEEF, 0, 0, 1, 0, 0, 32'h6006, 1);
    tbl[13] = mk(0, 0,       0, 0, 0,        0,           0, 0,            0, 0, 0, 0, 0, 32'h6006, 1);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_i_ack", 32'(i_ack), 0);
    cmp("rst_d_ack", 32'(d_ack), 0);
    cmp("rst_m_we", 32'(m_we), 0);
    cmp("rst_m_addr", m_addr, 0);
    cmp("rst_cnt", 32'(conflict_cnt), 0);
    rst_n = 1;
    cnt_m = 0;
    for (int k = 0; k < 14; k++) begin
      v = tbl[k];
      i_req = v.ireq; i_addr = v.iaddr; d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr;
      d_wdata = v.dwdata; d_dsize = v.dsize; m_rdata = v.rdata;
      if (v.ireq && v.dreq) cnt_m++;
      e.ei = v.ei; e.eie = v.eie; e.ed = v.ed; e.ede = v.ede; e.ewe = v.ewe;
      e.eaddr = v.eaddr; e.ewdata = v.dwdata; e.erdata = v.rdata; e.edsize = v.edsize; e.ecnt = cnt_m;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      cmp($sformatf("v%0d_i_ack", k), 32'(i_ack), 32'(g.ei));
      cmp($sformatf("v%0d_i_err", k), 32'(i_err), 32'(g.eie));
      cmp($sformatf("v%0d_d_ack", k), 32'(d_ack), 32'(g.ed));
      cmp($sformatf("v%0d_d_err", k), 32'(d_err), 32'(g.ede));
      cmp($sformatf("v%0d_m_we", k), 32'(m_we), 32'(g.ewe));
      cmp($sformatf("v%0d_m_addr", k), m_addr, g.eaddr);
      cmp($sformatf("v%0d_m_dsize", k), 32'(m_dsize), 32'(g.edsize));
      cmp($sformatf("v%0d_cnt", k), 32'(conflict_cnt), g.ecnt);
      if (g.ed) cmp($sformatf("v%0d_m_wdata", k), m_wdata, g.ewdata);
      if (g.ei) cmp($sformatf("v%0d_i_rdata", k), i_rdata, g.erdata);
      if (g.ed && !g.ede) cmp($sformatf("v%0d_d_rdata", k), d_rdata, g.erdata);
    end
    // Both requesters held for 20 edges: grant pattern, then counter saturation.
    do_reset();
    i_req = 1; i_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h7000; d_dsize = 3;
    for (int n = 1; n <= 20; n++) begin
`ifdef MEM_PORT_ARB_RR_EN
      e.ed = (n % 2) == 1;
`else
      e.ed = 1'b1;
`endif
      e.ei = ~e.ed;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      if (n <= 4) begin
        cmp($sformatf("tie%0d_d_ack", n), 32'(d_ack), 32'(g.ed));
        cmp($sformatf("tie%0d_i_ack", n), 32'(i_ack), 32'(g.ei));
      end
      if (n == 4) cmp("tie_cnt4", 32'(conflict_cnt), 4);
      if (n == 15 || n == 20) cmp($sformatf("sat_cnt4_at%0d", n), 32'(conflict_cnt4), 15);
    end
    cmp("nowrap_cnt16", 32'(conflict_cnt), 20);
    // Reset asserted in the middle of a granted write.
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h8000; d_wdata = 32'h5A5A5A5A; d_dsize = 3;
    @(posedge clk);
    #1;
    cmp("mid_m_we_before", 32'(m_we), 1);
    cmp("mid_d_ack_before", 32'(d_ack), 1);
    w0 = writes;
    #2 rst_n = 0;
    #1;
    cmp("mid_m_we_async", 32'(m_we), 0);
    cmp("mid_d_ack_async", 32'(d_ack), 0);
    cmp("mid_m_addr_async", m_addr, 0);
    @(posedge clk);
    #1;
    cmp("mid_no_write", writes, w0);
    cmp("mid_d_ack_held", 32'(d_ack), 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    cmp("post_rst_d_ack", 32'(d_ack), 1);
    cmp("post_rst_m_addr", m_addr, 32'h8000);
    d_req = 0;
    @(posedge clk);
    #1;
    cmp("post_rst_idle_we", 32'(m_we), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
